// File: rtl/ppu_oam_pkg.sv
// ppu_oam_pkg: shared types and constants for the OAM sprite pipeline
package ppu_oam_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, COPY, OVF, DONE} eval_state_t;
    localparam int         SPR_H8     = 8;
    localparam int         SPR_H16    = 16;
    localparam int         SEC_BYTES  = 32;
    localparam logic [7:0] CLEAR_BYTE = 8'hFF;
endpackage

// File: rtl/spr_range_cmp.sv
// spr_range_cmp: tells whether a sprite Y byte covers the current scanline
// Ports: V scanline, OB sprite Y, OBJ_H16 height select, in_range result
module spr_range_cmp
    import ppu_oam_pkg::*;
(
    input  logic [7:0] V,
    input  logic [7:0] OB,
    input  logic       OBJ_H16,
    output logic       in_range
);
    logic [8:0] d;
    assign d = {1'b0, V} - {1'b0, OB};
    // A borrow means the sprite starts below the scanline.
    assign in_range = !d[8] && (d[7:0] < (OBJ_H16 ? 8'(SPR_H16) : 8'(SPR_H8)));
endmodule

// File: rtl/oam_eval.sv
// oam_eval: clears secondary OAM and copies up to 8 in-range sprites into it
// Ports: PCLK/n_RES clock and async reset; n_W3/CPU_DB OAMADDR load;
//   CLR_START/EVAL_START/EVAL_EN/CLR_FLAGS control; OBJ_H16/V range inputs;
//   OB OAM read data; n_OAM/OAM8/OB_WE/OB_WD OAM address and write port;
//   OAMCTR2/SPR_OV/S0_IN status flags; EVAL_BUSY not idle
module oam_eval
    import ppu_oam_pkg::*;
#(
    parameter int         SEC_BYTES  = ppu_oam_pkg::SEC_BYTES,
    parameter logic [7:0] CLEAR_BYTE = ppu_oam_pkg::CLEAR_BYTE
) (
    input  logic       PCLK,
    input  logic       n_RES,
    input  logic       n_W3,
    input  logic [7:0] CPU_DB,
    input  logic       CLR_START,
    input  logic       EVAL_START,
    input  logic       EVAL_EN,
    input  logic       CLR_FLAGS,
    input  logic       OBJ_H16,
    input  logic [7:0] V,
    input  logic [7:0] OB,
    output logic [7:0] n_OAM,
    output logic       OAM8,
    output logic       OB_WE,
    output logic [7:0] OB_WD,
    output logic       OAMCTR2,
    output logic       SPR_OV,
    output logic       S0_IN,
    output logic       EVAL_BUSY
);
    eval_state_t state, state_n;
    logic [7:0] pa, pa_n, ob_lat;
    logic [4:0] sa, sa_n;
    logic [1:0] cnt, cnt_n;
    logic [8:0] pa_sum;
    logic ph, ph_n, first, first_n;
    logic hit, sa_last, s0_set, ov_set, full_set;

    // In OVF the step is a single R clock, so OB is tested live; otherwise the latched Y.
    spr_range_cmp u_cmp (
        .V(V),
        .OB(state == OVF ? OB : ob_lat),
        .OBJ_H16(OBJ_H16),
        .in_range(hit)
    );

    assign sa_last   = (sa == 5'(SEC_BYTES - 1));
    assign EVAL_BUSY = (state != IDLE);
    assign OAM8      = ph;
    assign OB_WE     = ph;
    assign OB_WD     = (state == CLEAR) ? CLEAR_BYTE : ob_lat;
    assign n_OAM     = (state == IDLE || state == DONE) ? 8'hFF : ph ? ~{3'b000, sa} : ~pa;

    always_comb begin
        state_n  = state;
        pa_n     = pa;
        sa_n     = sa;
        cnt_n    = cnt;
        ph_n     = ~ph;
        first_n  = first;
        pa_sum   = {1'b0, pa};
        s0_set   = 1'b0;
        ov_set   = 1'b0;
        full_set = 1'b0;
        case (state)
            IDLE: begin
                ph_n = 1'b0;
                if (!n_W3) pa_n = CPU_DB;
                if (CLR_START) begin
                    state_n = CLEAR;
                    sa_n    = '0;
                end else if (EVAL_START) begin
                    state_n = SCAN;
                    first_n = 1'b1;
                end
            end
            CLEAR: if (ph) begin
                sa_n = sa + 5'd1;
                if (sa_last) state_n = IDLE;
            end
            SCAN: if (ph) begin
                first_n = 1'b0;
                pa_sum  = {1'b0, pa} + (hit ? 9'd1 : 9'd4);
                pa_n    = pa_sum[7:0];
                if (hit) begin
                    s0_set  = first;
                    sa_n    = sa + 5'd1;
                    cnt_n   = 2'd3;
                    state_n = COPY;
                end
                if (pa_sum[8]) state_n = DONE;
            end
            COPY: if (ph) begin
                pa_sum = {1'b0, pa} + 9'd1;
                pa_n   = pa_sum[7:0];
                sa_n   = sa + 5'd1;
                cnt_n  = cnt - 2'd1;
                if (cnt == 2'd1) state_n = SCAN;
                if (sa_last) begin
                    full_set = 1'b1;
                    state_n  = OVF;
                end
                if (pa_sum[8]) state_n = DONE;
            end
            OVF: begin
                ph_n = 1'b0;
                if (hit) begin
                    ov_set  = 1'b1;
                    state_n = DONE;
                end else begin
                    // +5 rather than +4 reproduces the original hardware's skew into sprite bytes.
                    pa_sum = {1'b0, pa} + 9'd5;
                    pa_n   = pa_sum[7:0];
                    if (pa_sum[8]) state_n = DONE;
                end
            end
            DONE: begin
                ph_n = 1'b0;
                if (!EVAL_EN) begin
                    state_n = IDLE;
                    pa_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!EVAL_EN && (state == SCAN || state == COPY || state == OVF)) begin
            state_n  = IDLE;
            pa_n     = '0;
            sa_n     = '0;
            ph_n     = 1'b0;
            s0_set   = 1'b0;
            ov_set   = 1'b0;
            full_set = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) begin
            state   <= IDLE;
            pa      <= '0;
            sa      <= '0;
            cnt     <= '0;
            ph      <= 1'b0;
            first   <= 1'b0;
            ob_lat  <= '0;
            OAMCTR2 <= 1'b0;
            SPR_OV  <= 1'b0;
            S0_IN   <= 1'b0;
        end else begin
            state   <= state_n;
            pa      <= pa_n;
            sa      <= sa_n;
            cnt     <= cnt_n;
            ph      <= ph_n;
            first   <= first_n;
            if (!ph && (state == SCAN || state == COPY)) ob_lat <= OB;
            OAMCTR2 <= full_set | (OAMCTR2 & ~CLR_START);
            SPR_OV  <= ov_set | (SPR_OV & ~CLR_FLAGS);
            S0_IN   <= s0_set | (S0_IN & ~CLR_FLAGS);
        end
    end
endmodule

// File: tb/tb_oam_eval.sv
// tb_oam_eval: directed scoreboard bench for oam_eval with an OAM memory model
module tb_oam_eval;
    logic PCLK = 1'b0, n_RES = 1'b0, n_W3 = 1'b1, CLR_START = 1'b0, EVAL_START = 1'b0;
    logic EVAL_EN = 1'b0, CLR_FLAGS = 1'b0, OBJ_H16 = 1'b0;
    logic [7:0] CPU_DB = 8'h00, V = 8'h00, OB;
    logic [7:0] n_OAM, OB_WD;
    logic OAM8, OB_WE, OAMCTR2, SPR_OV, S0_IN, EVAL_BUSY;
    logic [7:0] prim [256];
    logic [7:0] sec [32];
    logic [16:0] exp_q [$];
    int checks = 0, errors = 0;

    always #5 PCLK = ~PCLK;

    oam_eval dut (
        .PCLK(PCLK), .n_RES(n_RES), .n_W3(n_W3), .CPU_DB(CPU_DB),
        .CLR_START(CLR_START), .EVAL_START(EVAL_START), .EVAL_EN(EVAL_EN),
        .CLR_FLAGS(CLR_FLAGS), .OBJ_H16(OBJ_H16), .V(V), .OB(OB),
        .n_OAM(n_OAM), .OAM8(OAM8), .OB_WE(OB_WE), .OB_WD(OB_WD),
        .OAMCTR2(OAMCTR2), .SPR_OV(SPR_OV), .S0_IN(S0_IN), .EVAL_BUSY(EVAL_BUSY)
    );

    assign OB = OAM8 ? sec[~n_OAM[4:0]] : prim[~n_OAM];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge PCLK) if (n_RES && OB_WE) begin
        if (exp_q.size() == 0) chk("wr_unexpected", {15'd0, OAM8, ~n_OAM, OB_WD}, 32'd0);
        else chk("wr", {15'd0, OAM8, ~n_OAM, OB_WD}, {15'd0, exp_q.pop_front()});
        sec[~n_OAM[4:0]] = OB_WD;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic push(input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, 3'b000, a, d});
    endtask

    task automatic fill_prim();
        for (int i = 0; i < 256; i++) prim[i] = 8'hFF;
    endtask

    task automatic do_clear();
        int n = 0;
        for (int i = 0; i < 32; i++) push(5'(i), 8'hFF);
        CLR_START = 1'b1; CLR_FLAGS = 1'b1;
        tick();
        CLR_START = 1'b0; CLR_FLAGS = 1'b0;
        chk("clr_flags", {29'd0, OAMCTR2, SPR_OV, S0_IN}, 32'd0);
        while (EVAL_BUSY && n < 200) begin n++; tick(); end
        chk("clear_len", n, 64);
        chk("clear_pending", exp_q.size(), 0);
    endtask

    // DONE is the only busy state showing an idle address on two clocks running.
    task automatic wait_done(output int t);
        logic prev, cur;
        prev = 1'b0;
        t = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PCLK);
            cur = EVAL_BUSY && n_OAM == 8'hFF && !OAM8;
            if (cur && prev) break;
            prev = cur;
            t++;
        end
    endtask

    task automatic run_eval(input int exp_len, input logic [2:0] exp_flags, input string tag);
        int t;
        EVAL_EN = 1'b1; EVAL_START = 1'b1;
        tick();
        EVAL_START = 1'b0;
        wait_done(t);
        chk({tag, "_len"}, t, exp_len);
        chk({tag, "_flags"}, {29'd0, OAMCTR2, SPR_OV, S0_IN}, {29'd0, exp_flags});
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_hold"}, EVAL_BUSY, 1);
        EVAL_EN = 1'b0;
        tick();
        chk({tag, "_idle"}, EVAL_BUSY, 0);
    endtask

    task automatic single_setup();
        fill_prim();
        V = 8'd12; OBJ_H16 = 1'b0;
        prim[0] = 8'd10; prim[1] = 8'h21; prim[2] = 8'h22; prim[3] = 8'h23;
    endtask

    task automatic single_expect();
        for (int k = 0; k < 4; k++) push(5'(k), prim[k]);
        for (int i = 0; i < 63; i++) push(5'd4, 8'hFF);
    endtask

    task automatic eight_setup();
        fill_prim();
        V = 8'd12; OBJ_H16 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prim[4*i] = 8'(12 - i);
            for (int k = 1; k < 4; k++) prim[4*i+k] = 8'(8'h30 + 4*i + k);
        end
        for (int j = 0; j < 32; j++) push(5'(j), prim[j]);
    endtask

    initial begin
        fill_prim();
        #1;
        chk("rst_noam", n_OAM, 8'hFF);
        chk("rst_ctl", {29'd0, OAM8, OB_WE, EVAL_BUSY}, 32'd0);
        chk("rst_wd", OB_WD, 8'h00);
        chk("rst_flags", {29'd0, OAMCTR2, SPR_OV, S0_IN}, 32'd0);
        tick(2);
        n_RES = 1'b1;
        tick();

        do_clear();
        single_setup();
        single_expect();
        run_eval(134, 3'b001, "single");

        do_clear();
        eight_setup();
        prim[32] = 8'd11;
        run_eval(65, 3'b111, "eight");

        do_clear();
        eight_setup();
        prim[37] = 8'd12;
        run_eval(66, 3'b111, "ovf_bug");

        do_clear();
        fill_prim();
        V = 8'd20; OBJ_H16 = 1'b1;
        prim[8] = 8'd5; prim[9] = 8'h61; prim[10] = 8'h62; prim[11] = 8'h63;
        n_W3 = 1'b0; CPU_DB = 8'h08;
        tick();
        n_W3 = 1'b1;
        for (int k = 0; k < 4; k++) push(5'(k), prim[8+k]);
        for (int i = 0; i < 61; i++) push(5'd4, 8'hFF);
        run_eval(130, 3'b001, "h16_hit");

        do_clear();
        prim[8] = 8'd4;
        n_W3 = 1'b0; CPU_DB = 8'h08;
        tick();
        n_W3 = 1'b1;
        push(5'd0, 8'd4);
        for (int i = 0; i < 61; i++) push(5'd0, 8'hFF);
        run_eval(124, 3'b000, "h16_miss");

        do_clear();
        single_setup();
        push(5'd0, 8'd10);
        EVAL_EN = 1'b1; EVAL_START = 1'b1;
        tick();
        EVAL_START = 1'b0;
        tick(2);
        chk("abort_s0_rise", S0_IN, 1);
        EVAL_EN = 1'b0;
        tick();
        chk("abort_idle", EVAL_BUSY, 0);
        chk("abort_noam", n_OAM, 8'hFF);
        chk("abort_flags", {29'd0, OAMCTR2, SPR_OV, S0_IN}, 32'd1);
        chk("abort_pending", exp_q.size(), 0);
        single_expect();
        run_eval(134, 3'b001, "after_abort");
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        chk("clr_flags_s0", S0_IN, 0);

        for (int i = 0; i < 32; i++) push(5'(i), 8'hFF);
        CLR_START = 1'b1;
        tick();
        CLR_START = 1'b0;
        tick(9);
        chk("pre_rst_we", OB_WE, 1);
        n_RES = 1'b0;
        #1;
        chk("rst_mid_noam", n_OAM, 8'hFF);
        chk("rst_mid_ctl", {29'd0, OAM8, OB_WE, EVAL_BUSY}, 32'd0);
        chk("rst_mid_wd", OB_WD, 8'h00);
        exp_q.delete();
        tick();
        n_RES = 1'b1;
        tick();
        chk("post_rst_idle", EVAL_BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oam_eval.md
# oam_eval

Sprite evaluation stage that sits directly upstream of the OAM block and drives its address and control inputs. It clears secondary OAM, scans the 64 primary OAM entries for sprites in range of the current scanline, and copies up to 8 of them into secondary OAM. It also raises the secondary-full and sprite-overflow indications. Data read from OAM returns on the OAM block's buffer output and feeds back into this block.

## Interface
Parameters:
- SEC_BYTES, 32, secondary OAM size in bytes (8 sprites × 4)
- CLEAR_BYTE, 8'hFF, fill value written during secondary clear

Ports:
- PCLK  in  1  pixel clock; all state updates on rising edge
- n_RES  in  1  reset, asynchronous, active-low
- n_W3  in  1  CPU OAMADDR write strobe, active-low, one clock wide
- CPU_DB  in  8  CPU data bus, sampled when n_W3=0
- CLR_START  in  1  one-clock pulse; starts the secondary clear
- EVAL_START  in  1  one-clock pulse; starts evaluation
- EVAL_EN  in  1  high for the evaluation window; a low level aborts evaluation
- CLR_FLAGS  in  1  clears SPR_OV and S0_IN
- OBJ_H16  in  1  sprite height select: 0 = 8 lines, 1 = 16 lines
- V  in  8  current scanline
- OB  in  8  byte read back from OAM (OAM block buffer output)
- n_OAM  out  8  inverted OAM address to the OAM block
- OAM8  out  1  1 = address targets secondary OAM
- OB_WE  out  1  secondary OAM write enable
- OB_WD  out  8  secondary write data
- OAMCTR2  out  1  secondary OAM full (8 sprites found)
- SPR_OV  out  1  sprite overflow flag
- S0_IN  out  1  sprite 0 is in range on this line
- EVAL_BUSY  out  1  state is not IDLE

## Operation
- Registers:
  - PA[7:0]: primary address.
  - SA[4:0]: secondary address.
  - PH: step phase. R = 0, W = 1.
  - CNT[1:0]: bytes remaining in a copy.
  - FIRST: first Y check of the scan.
- A step is two clocks:
  - R phase: OAM8=0, n_OAM=~PA.
  - W phase: OAM8=1, n_OAM=~{3'b000,SA}, OB_WD = the OB value latched at the end of R.
- OB_WE is asserted only in the W phase, in CLEAR, SCAN and COPY.
- Range test: d = {1'b0,V} − {1'b0,OB}. The sprite is in range iff d[8]=0 and d[7:0] < (OBJ_H16 ? 16 : 8).
- States:
  - IDLE:
    - n_W3=0 loads PA=CPU_DB.
    - CLR_START → CLEAR with SA=0.
    - EVAL_START → SCAN with PH=R and FIRST=1.
  - CLEAR:
    - OB_WD=CLEAR_BYTE on every W phase.
    - SA++ after each W.
    - When SA wraps 31→0 → IDLE.
  - SCAN:
    - Y is written to SA unconditionally.
    - If in range: S0_IN=1 when FIRST; SA++, PA++, CNT=3 → COPY.
    - Otherwise PA += 4.
    - FIRST is cleared after the step.
  - COPY:
    - Per step: PA++, SA++, CNT−−.
    - When CNT reaches 0 → SCAN.
    - If SA wraps to 0 on that step: OAMCTR2=1 → OVF.
  - OVF:
    - R phase only; OB_WE=0.
    - If in range: SPR_OV=1 → DONE.
    - Otherwise PA += 5. This replicates the hardware +4+1 bug.
  - DONE: holds until EVAL_EN=0 → IDLE with PA=0.
- Primary wrap: any PA increment that carries out of bit 7 (in SCAN, COPY or OVF) → DONE.
- Abort: EVAL_EN=0 in SCAN, COPY or OVF → IDLE with PA=0. SA is reset to 0; OAMCTR2, SPR_OV and S0_IN hold.
- CLR_FLAGS clears SPR_OV and S0_IN in any state. When it coincides with a set event, the set wins.
- OAMCTR2 clears on CLR_START.
- n_W3 outside IDLE is ignored. CLR_START and EVAL_START outside IDLE are ignored. If both arrive in the same IDLE clock, CLR_START wins.

## Timing
- Reset values:
  - State IDLE; PA, SA, PH, CNT = 0.
  - n_OAM=8'hFF, OAM8=0, OB_WE=0, OB_WD=8'h00.
  - OAMCTR2, SPR_OV, S0_IN, EVAL_BUSY = 0.
- Reset is asynchronous. Asserting it mid-operation returns to the reset values immediately, with no partial write completion.
- The start pulse is registered. The first R phase addresses OAM on the clock after the pulse.
- OB is valid at the end of R, one clock after the address is driven. It is latched on the R→W edge.
- Durations:
  - CLEAR: exactly 64 clocks.
  - Full scan with no hits: 128 clocks.
  - Each hit: 8 clocks, i.e. 4 steps.
- Flags (SPR_OV, OAMCTR2, S0_IN) rise on the clock edge that ends the deciding step.
- EVAL_BUSY is combinational from state.

## Structure
- Shared package ppu_oam_pkg:
  - eval_state_t enum: IDLE, CLEAR, SCAN, COPY, OVF, DONE.
  - SPR_H8=8, SPR_H16=16.
  - SEC_BYTES, CLEAR_BYTE.
- One sub-module, spr_range_cmp: V, OB, OBJ_H16 → in_range. Combinational. It is reused by the later sprite-0 hit logic.

## Test plan
- Clear: CLR_START → 32 W-phase writes of 8'hFF to SA 0..31 over 64 clocks, then IDLE with SA=0.
- Single hit: sprite 0 Y=10, V=12, OBJ_H16=0, all other Y=8'hFF → 4 bytes copied to SA 0..3, S0_IN=1, SPR_OV=0, DONE after PA wraps.
- Eight hits: sprites 0..7 in range → OAMCTR2=1 after the 32nd write. A 9th in-range sprite at index 8 → SPR_OV=1. No further OB_WE pulses.
- Overflow bug: 8 hits, then sprite 9 with its Y value placed at byte offset 1 (the only in-range byte) → SPR_OV=1, confirming the PA += 5 stepping.
- Start offset and height: n_W3 with CPU_DB=8'h08, OBJ_H16=1, V=20, Y=5 at 8'h08 → in range (d=15). Y=4 → not in range. Scan starts at PA=8.
- Abort and reset: EVAL_EN dropped mid-COPY → IDLE, PA=0, flags held. n_RES pulsed during CLEAR → all outputs at reset values within the same cycle.
